// File: rtl/mvu_job_scheduler.sv
// mvu_job_scheduler: round-robin sharing of one MVU command port among harts,
// with per-hart completion/timeout interrupts and a RUN-state watchdog.
module mvu_job_scheduler #(
   parameter int NUM_HARTS = 8,
   parameter int CMD_W     = 32,
   parameter int WDT_W     = 20
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_HARTS-1:0]         req_valid,
   input  logic [NUM_HARTS*CMD_W-1:0]   req_cmd,
   output logic [NUM_HARTS-1:0]         req_ready,
   output logic                         mvu_cmd_vld,
   output logic [CMD_W-1:0]             mvu_cmd,
   output logic [$clog2(NUM_HARTS)-1:0] mvu_hart,
   input  logic                         mvu_cmd_rdy,
   input  logic                         mvu_done,
   output logic                         mvu_abort,
   output logic [NUM_HARTS-1:0]         irq_done,
   output logic [NUM_HARTS-1:0]         irq_err,
   output logic                         busy
);
   localparam int HW = $clog2(NUM_HARTS);
   typedef enum logic [1:0] {IDLE, ISSUE, RUN} state_t;
   state_t state, state_nxt;
   logic [HW-1:0] rr_ptr, grant, idx;
   logic [WDT_W-1:0] wdt;
   logic [NUM_HARTS-1:0] owner_oh;
   logic any_req, take, finish, expire, timeout;
   assign any_req  = |req_valid;
   assign owner_oh = NUM_HARTS'(1) << mvu_hart;
   // expiry is flagged in the cycle the counter would step onto all-ones
   assign expire   = ~wdt == WDT_W'(1);
   // descending scan so the requester closest to rr_ptr wins
   always_comb begin
      grant = rr_ptr;
      idx   = '0;
      for (int i = NUM_HARTS-1; i >= 0; i--) begin
         idx = HW'((int'(rr_ptr) + i) % NUM_HARTS);
         if (req_valid[idx]) grant = idx;
      end
   end
   always_comb begin
      state_nxt   = state;
      take        = state == IDLE && any_req;
      finish      = state == RUN && mvu_done;
      timeout     = state == RUN && !mvu_done && expire;
      req_ready   = (take && !rst) ? NUM_HARTS'(1) << grant : '0;
      mvu_cmd_vld = state == ISSUE;
      busy        = state != IDLE;
      if (take) state_nxt = ISSUE;
      if (state == ISSUE && mvu_cmd_rdy) state_nxt = RUN;
      if (finish || timeout) state_nxt = IDLE;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nxt;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rr_ptr    <= '0;
         mvu_cmd   <= '0;
         mvu_hart  <= '0;
         wdt       <= '0;
         mvu_abort <= 1'b0;
         irq_done  <= '0;
         irq_err   <= '0;
      end else begin
         mvu_abort <= timeout;
         irq_done  <= finish ? owner_oh : '0;
         irq_err   <= timeout ? owner_oh : '0;
         wdt       <= state == ISSUE ? '0 : state == RUN ? wdt + 1'b1 : wdt;
         if (take) begin
            mvu_cmd  <= req_cmd[grant*CMD_W +: CMD_W];
            mvu_hart <= grant;
            rr_ptr   <= grant == HW'(NUM_HARTS-1) ? '0 : grant + 1'b1;
         end
      end
endmodule

// File: tb/tb_mvu_job_scheduler.sv
// tb_mvu_job_scheduler: scenario tasks plus randomized jobs checked against a
// queue-free round-robin reference model; watchdog shortened to WDT_W=4.
module tb_mvu_job_scheduler;
   localparam int N = 8, CW = 32, WW = 4, HW = 3, TMO = 15;
   logic clk = 0, rst = 0;
   logic [N-1:0] req_valid = '0, req_ready, irq_done, irq_err;
   logic [N*CW-1:0] req_cmd = '0;
   logic mvu_cmd_vld, mvu_cmd_rdy = 0, mvu_done = 0, mvu_abort, busy;
   logic [CW-1:0] mvu_cmd;
   logic [HW-1:0] mvu_hart;
   int passed = 0, total = 0, rr = 0;
   logic [CW-1:0] cmds [N];
   int j_g, j_nrun;
   logic [CW-1:0] j_cmd;
   logic [HW-1:0] j_hart;
   logic [N-1:0] j_irqd, j_irqe;
   logic j_vld1, j_stable, j_abort, j_busy, j_quiet;

   mvu_job_scheduler #(.NUM_HARTS(N), .CMD_W(CW), .WDT_W(WW)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_cmd(req_cmd), .req_ready(req_ready),
      .mvu_cmd_vld(mvu_cmd_vld), .mvu_cmd(mvu_cmd), .mvu_hart(mvu_hart), .mvu_cmd_rdy(mvu_cmd_rdy),
      .mvu_done(mvu_done), .mvu_abort(mvu_abort), .irq_done(irq_done), .irq_err(irq_err), .busy(busy));

   always #5 clk = ~clk;

   function automatic int model_grant(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) begin
         logic [HW-1:0] k = HW'((rr + i) % N);
         if (v[k]) return (rr + i) % N;
      end
      return -1;
   endfunction

   task automatic load_cmds();
      for (int h = 0; h < N; h++) begin
         cmds[h] = $urandom;
         req_cmd[h*CW +: CW] = cmds[h];
      end
   endtask

   task automatic do_reset();
      @(negedge clk) rst = 1;
      @(negedge clk) rst = 0;
      rr = 0;
      @(posedge clk); #1;
   endtask

   // Runs one job from an IDLE cycle; returns while the completion pulse is visible.
   task automatic run_job(input int rdy_dly, input int done_dly, input bit drop);
      #1;
      j_g = -1;
      for (int h = 0; h < N; h++) if (req_ready == N'(1) << h) j_g = h;
      if (j_g >= 0) rr = (j_g + 1) % N;
      @(posedge clk); #1;
      if (drop && j_g >= 0) req_valid[j_g[HW-1:0]] = 1'b0;
      j_vld1 = mvu_cmd_vld; j_cmd = mvu_cmd; j_hart = mvu_hart; j_stable = 1;
      j_quiet = irq_done == 0 && irq_err == 0 && !mvu_abort;
      for (int i = 0; i < rdy_dly; i++) begin
         mvu_done = (i % 2 == 1);
         @(posedge clk); #1;
         mvu_done = 0;
         if (!mvu_cmd_vld || mvu_cmd !== j_cmd || mvu_hart !== j_hart || req_ready != 0 || irq_done != 0) j_stable = 0;
      end
      mvu_cmd_rdy = 1;
      @(posedge clk); #1;
      mvu_cmd_rdy = 0;
      j_nrun = -1; j_irqd = 0; j_irqe = 0; j_abort = 0; j_busy = 1;
      for (int k = 1; k <= 40 && j_nrun < 0; k++) begin
         mvu_done = (k == done_dly);
         @(posedge clk); #1;
         mvu_done = 0;
         if (irq_done != 0 || irq_err != 0 || mvu_abort) begin
            j_nrun = k; j_irqd = irq_done; j_irqe = irq_err; j_abort = mvu_abort; j_busy = busy;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1; req_valid = '1; mvu_cmd_rdy = 1; mvu_done = 1;
      #2;
      total++;
      if ({req_ready, mvu_cmd_vld, mvu_cmd, mvu_hart, mvu_abort, irq_done, irq_err, busy} !== '0)
         $display("FAIL reset_outputs got rdy=%b vld=%b busy=%b want all zero", req_ready, mvu_cmd_vld, busy);
      else passed++;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({req_ready, mvu_cmd_vld, mvu_cmd, mvu_hart, mvu_abort, irq_done, irq_err, busy} !== '0)
         $display("FAIL reset_held got rdy=%b vld=%b busy=%b want all zero", req_ready, mvu_cmd_vld, busy);
      else passed++;
      req_valid = '0; mvu_cmd_rdy = 0; mvu_done = 0;
      @(negedge clk) rst = 0;
      rr = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      load_cmds();
      req_valid = 8'b0000_0100;
      run_job(0, 10, 1);
      total++;
      if (j_g !== 2 || j_vld1 !== 1 || j_cmd !== cmds[2] || j_hart !== 3'd2)
         $display("FAIL single_grant got g=%0d vld=%b cmd=%h hart=%0d want g=2 vld=1 cmd=%h hart=2", j_g, j_vld1, j_cmd, j_hart, cmds[2]);
      else passed++;
      total++;
      if (j_irqd !== 8'b0000_0100 || j_irqe !== 0 || j_abort !== 0 || j_nrun !== 10 || j_busy !== 0)
         $display("FAIL single_done got irqd=%b irqe=%b abort=%b n=%0d busy=%b want 00000100 0 0 10 0", j_irqd, j_irqe, j_abort, j_nrun, j_busy);
      else passed++;
   endtask

   task automatic test_round_robin();
      int cnt [N];
      bit ok = 1;
      do_reset();
      for (int h = 0; h < N; h++) cnt[h] = 0;
      req_valid = '1;
      for (int n = 0; n <= N; n++) begin
         int exp = model_grant(req_valid);
         run_job(0, 3, 0);
         if (n < N && j_g >= 0) cnt[j_g]++;
         total++;
         if (j_g !== exp || j_irqd !== N'(1) << exp || j_nrun !== 3 || j_quiet !== 1)
            $display("FAIL rr_order job %0d got g=%0d irqd=%b n=%0d want g=%0d n=3", n, j_g, j_irqd, j_nrun, exp);
         else passed++;
      end
      req_valid = '0;
      for (int h = 0; h < N; h++) if (cnt[h] != 1) ok = 0;
      total++;
      if (!ok) $display("FAIL rr_fairness got counts not all one want one job per hart");
      else passed++;
   endtask

   task automatic test_rr5();
      do_reset();
      req_valid = 8'b0001_0000;
      run_job(0, 2, 1);
      req_valid = 8'b0100_0010;
      run_job(0, 2, 1);
      total++;
      if (j_g !== 6) $display("FAIL rr5_first got %0d want 6", j_g);
      else passed++;
      run_job(0, 2, 1);
      total++;
      if (j_g !== 1 || j_irqd !== 8'b0000_0010) $display("FAIL rr5_second got g=%0d irqd=%b want 1 00000010", j_g, j_irqd);
      else passed++;
   endtask

   task automatic test_stall();
      int exp;
      load_cmds();
      req_valid = N'(1) << $urandom_range(0, N-1);
      exp = model_grant(req_valid);
      run_job(7, 4, 1);
      total++;
      if (j_stable !== 1 || j_g !== exp || j_cmd !== cmds[exp] || j_nrun !== 4 || j_irqd !== N'(1) << exp)
         $display("FAIL stall got stable=%b g=%0d n=%0d irqd=%b want 1 %0d 4", j_stable, j_g, j_nrun, j_irqd, exp);
      else passed++;
   endtask

   task automatic test_watchdog();
      req_valid = 8'b1000_0000;
      run_job(1, 0, 1);
      total++;
      if (j_irqe !== 8'b1000_0000 || j_irqd !== 0 || j_abort !== 1 || j_nrun !== TMO)
         $display("FAIL wdt_expire got irqe=%b irqd=%b abort=%b n=%0d want 10000000 0 1 %0d", j_irqe, j_irqd, j_abort, j_nrun, TMO);
      else passed++;
      req_valid = 8'b0000_0001;
      run_job(0, TMO, 1);
      total++;
      if (j_irqd !== 8'b0000_0001 || j_irqe !== 0 || j_abort !== 0 || j_nrun !== TMO || j_quiet !== 1)
         $display("FAIL wdt_done_wins got irqd=%b irqe=%b abort=%b n=%0d want 00000001 0 0 %0d", j_irqd, j_irqe, j_abort, j_nrun, TMO);
      else passed++;
   endtask

   task automatic test_reset_mid();
      bit quiet = 1;
      req_valid = 8'b0000_1000;
      @(posedge clk); #1;
      req_valid = 8'b0010_1000;
      mvu_cmd_rdy = 1;
      @(posedge clk); #1;
      mvu_cmd_rdy = 0;
      repeat (3) @(posedge clk);
      #2 rst = 1;
      #1;
      total++;
      if ({req_ready, mvu_cmd_vld, mvu_cmd, mvu_hart, mvu_abort, irq_done, irq_err, busy} !== '0)
         $display("FAIL reset_mid got rdy=%b vld=%b busy=%b want all zero", req_ready, mvu_cmd_vld, busy);
      else passed++;
      req_valid = '0;
      @(negedge clk) rst = 0;
      rr = 0;
      @(posedge clk); #1;
      mvu_done = 1;
      @(posedge clk); #1;
      mvu_done = 0;
      for (int i = 0; i < 3; i++) begin
         if (irq_done != 0 || irq_err != 0 || mvu_abort || busy) quiet = 0;
         @(posedge clk); #1;
      end
      total++;
      if (!quiet) $display("FAIL spurious_done got irq or busy activity want none");
      else passed++;
      req_valid = 8'b0010_1000;
      run_job(0, 2, 1);
      total++;
      if (j_g !== 3 || j_irqd !== 8'b0000_1000) $display("FAIL post_reset_grant got g=%0d irqd=%b want 3 00001000", j_g, j_irqd);
      else passed++;
      req_valid = '0;
   endtask

   task automatic test_random();
      load_cmds();
      for (int n = 0; n < 30; n++) begin
         int exp, d, en;
         logic [N-1:0] ed, ee;
         req_valid = req_valid | N'($urandom);
         if ($urandom_range(0, 3) == 0) req_valid = req_valid & ~(N'(1) << $urandom_range(0, N-1));
         if (req_valid == 0) req_valid = N'(1) << $urandom_range(0, N-1);
         exp = model_grant(req_valid);
         d = $urandom_range(0, 18);
         en = (d >= 1 && d <= TMO) ? d : TMO;
         ed = (d >= 1 && d <= TMO) ? N'(1) << exp : '0;
         ee = (d >= 1 && d <= TMO) ? '0 : N'(1) << exp;
         run_job($urandom_range(0, 3), d, 1);
         total++;
         if (j_g !== exp || j_cmd !== cmds[exp] || j_hart !== HW'(exp) || j_vld1 !== 1 || j_stable !== 1 || j_quiet !== 1)
            $display("FAIL rand_issue %0d got g=%0d cmd=%h hart=%0d stable=%b want g=%0d cmd=%h", n, j_g, j_cmd, j_hart, j_stable, exp, cmds[exp]);
         else passed++;
         total++;
         if (j_irqd !== ed || j_irqe !== ee || j_abort !== (ee != 0) || j_nrun !== en || j_busy !== 0)
            $display("FAIL rand_end %0d got irqd=%b irqe=%b abort=%b n=%0d want %b %b %0d", n, j_irqd, j_irqe, j_abort, j_nrun, ed, ee, en);
         else passed++;
      end
      req_valid = '0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_rr5();
      test_stall();
      test_watchdog();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
